// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and instruction-fetch sequencer for the
// 8-bit computer.
//
// It fetches the byte at pc from instruction memory, presents it to decode,
// then waits for the jump decision and loads the jump target, increments pc,
// or holds it.
//
// Optional feature: define PC_CALL_STACK_EN to add the call/ret inputs and a
// STACK_DEPTH x ADDR_W return stack. STACK_DEPTH must be a power of 2 and at
// least 2.
//
// Handshake: the memory request is a level. mem_req stays high, with mem_addr
// stable, until the first cycle in which mem_ack is sampled high. The fetch is
// accepted on that rising edge. mem_ack is ignored while mem_req is low. The
// decode inputs (jmp, pc_inc, jmp_addr, halt, call, ret) are sampled only when
// dec_valid is high in the DECIDE state.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   mem_req      fetch request (FETCH state, not in reset)
//   mem_addr     fetch address (always equal to pc)
//   mem_ack      memory returns instr_in this cycle
//   instr_in     instruction byte from memory
//   instr_out    latched instruction for decode
//   instr_valid  one-cycle pulse when instr_out is updated
//   dec_valid    decode inputs are valid this cycle
//   jmp, pc_inc  jump decision
//   jmp_addr     jump / call target
//   halt         stop sequencing until reset
//   call, ret    (PC_CALL_STACK_EN only) subroutine call / return
//   pc           program counter
//   halted       sequencer is in HALT
//   err          sticky protocol-error flag
//   state_dbg    current FSM state (debug)
module pc_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        instr_in,
  output logic [7:0]        instr_out,
  output logic              instr_valid,
  input  logic              dec_valid,
  input  logic              jmp,
  input  logic              pc_inc,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              halt,
`ifdef PC_CALL_STACK_EN
  input  logic              call,
  input  logic              ret,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              err,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] DECIDE = 2'd1;
  localparam logic [1:0] HALT   = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc_seq;

  // pc + 1 wraps naturally at ADDR_W bits.
  assign pc_seq    = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign mem_addr  = pc;
  // Both outputs are forced low while rst is high, even when the state
  // register still holds FETCH.
  assign mem_req   = (state == FETCH) && !rst;
  assign halted    = (state == HALT) && !rst;
  assign state_dbg = state;

`ifdef PC_CALL_STACK_EN
  // sp counts the occupied entries (0..STACK_DEPTH). It is one bit wider
  // than the index so that "full" can be told apart from "empty".
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_dec;
  logic              stack_full;
  logic              stack_empty;
  logic              push_ok;

  assign sp_dec      = sp - SP_W'(1);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign push_ok     = !rst && (state == DECIDE) && dec_valid && !halt &&
                       !ret && call && !stack_full;

  // The stack contents need no reset; only sp decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) stack_mem[sp[SP_W-2:0]] <= pc_seq;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_VEC;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      err         <= 1'b0;
`ifdef PC_CALL_STACK_EN
      sp          <= '0;
`endif
    end else begin
      instr_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (mem_ack) begin
            instr_out   <= instr_in;
            instr_valid <= 1'b1;
            state       <= DECIDE;
          end
        end
        DECIDE: begin
          if (dec_valid) begin
            if (halt) begin
              state <= HALT;
            end else begin
              state <= FETCH;
`ifdef PC_CALL_STACK_EN
              if (ret) begin
                // A return on an empty stack falls through to the next
                // instruction.
                if (call || stack_empty) err <= 1'b1;
                if (stack_empty) begin
                  pc <= pc_seq;
                end else begin
                  pc <= stack_mem[sp_dec[SP_W-2:0]];
                  sp <= sp_dec;
                end
              end else if (call) begin
                // On overflow the return address is lost, but the jump
                // still happens.
                if (stack_full) err <= 1'b1;
                else            sp  <= sp + SP_W'(1);
                pc <= jmp_addr;
              end else
`endif
              if (jmp) begin
                pc <= jmp_addr;
                if (pc_inc) err <= 1'b1;
              end else if (pc_inc) begin
                pc <= pc_seq;
              end
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer.
//
// The reference model works per instruction. It keeps the expected pc, the
// err and halted flags, the last instruction and a return stack. Expected
// fetch addresses go into exp_q, and each fetch pops one address from it.
module tb_pc_sequencer;

`ifdef PC_CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] instr_in;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic       dec_valid;
  logic       jmp;
  logic       pc_inc;
  logic [7:0] jmp_addr;
  logic       halt;
  logic       call;
  logic       ret;
  logic [7:0] pc;
  logic       halted;
  logic       err;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .instr_in    (instr_in),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .dec_valid   (dec_valid),
    .jmp         (jmp),
    .pc_inc      (pc_inc),
    .jmp_addr    (jmp_addr),
    .halt        (halt),
`ifdef PC_CALL_STACK_EN
    .call        (call),
    .ret         (ret),
`endif
    .pc          (pc),
    .halted      (halted),
    .err         (err),
    .state_dbg   (state_dbg)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] stk[$];
  logic [7:0] exp_pc;
  logic [7:0] exp_instr;
  logic       exp_err;
  logic       exp_halted;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ack   = 1'b0;
    dec_valid = 1'b0;
    step();
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_pc", pc, 8'h00);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_halted", halted, 1'b0);
    check_eq("rst_instr_valid", instr_valid, 1'b0);
    check_eq("rst_instr_out", instr_out, 8'h00);
    rst        = 1'b0;
    exp_pc     = 8'h00;
    exp_err    = 1'b0;
    exp_halted = 1'b0;
    exp_instr  = 8'h00;
    exp_q.delete();
    stk.delete();
    exp_q.push_back(8'h00);
    #1;
  endtask

  // Instruction-level reference: the effect of one decision on pc, err and
  // the return stack.
  task automatic model_decide(input logic h, input logic c, input logic r,
                              input logic j, input logic inc,
                              input logic [7:0] addr);
    if (h) begin
      exp_halted = 1'b1;
    end else if (STACK_EN && r) begin
      if (c) exp_err = 1'b1;
      if (stk.size() == 0) begin
        exp_pc  = exp_pc + 8'd1;
        exp_err = 1'b1;
      end else begin
        exp_pc = stk.pop_back();
      end
    end else if (STACK_EN && c) begin
      if (stk.size() == DEPTH) exp_err = 1'b1;
      else stk.push_back(exp_pc + 8'd1);
      exp_pc = addr;
    end else if (j) begin
      exp_pc = addr;
      if (inc) exp_err = 1'b1;
    end else if (inc) begin
      exp_pc = exp_pc + 8'd1;
    end
    if (!exp_halted) exp_q.push_back(exp_pc);
  endtask

  task automatic do_fetch(input int delay, input logic [7:0] instr);
    logic [7:0] a;
    check_eq("fetch_q_nonempty", exp_q.size() > 0, 1'b1);
    a = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    for (int i = 0; i < delay; i++) begin
      mem_ack  = 1'b0;
      instr_in = 8'($urandom);
      check_eq("stall_mem_req", mem_req, 1'b1);
      check_eq("stall_mem_addr", mem_addr, a);
      check_eq("stall_instr_valid", instr_valid, 1'b0);
      step();
    end
    check_eq("fetch_mem_req", mem_req, 1'b1);
    check_eq("fetch_mem_addr", mem_addr, a);
    mem_ack  = 1'b1;
    instr_in = instr;
    step();
    mem_ack   = 1'b0;
    instr_in  = 8'($urandom);
    exp_instr = instr;
    check_eq("ack_instr_valid", instr_valid, 1'b1);
    check_eq("ack_instr_out", instr_out, exp_instr);
    check_eq("ack_mem_req", mem_req, 1'b0);
  endtask

  task automatic do_decide(input int wait_c, input logic h, input logic c,
                           input logic r, input logic j, input logic inc,
                           input logic [7:0] addr);
    for (int i = 0; i < wait_c; i++) begin
      // Stray acks and garbage decode inputs must all be ignored here.
      dec_valid = 1'b0;
      mem_ack   = 1'($urandom_range(0, 1));
      instr_in  = 8'($urandom);
      halt      = 1'($urandom_range(0, 1));
      jmp       = 1'($urandom_range(0, 1));
      pc_inc    = 1'($urandom_range(0, 1));
      call      = 1'($urandom_range(0, 1));
      ret       = 1'($urandom_range(0, 1));
      jmp_addr  = 8'($urandom);
      step();
      check_eq("wait_instr_valid", instr_valid, 1'b0);
      check_eq("wait_instr_out", instr_out, exp_instr);
      check_eq("wait_mem_req", mem_req, 1'b0);
      check_eq("wait_pc", pc, exp_pc);
    end
    mem_ack   = 1'b0;
    dec_valid = 1'b1;
    halt      = h;
    call      = c;
    ret       = r;
    jmp       = j;
    pc_inc    = inc;
    jmp_addr  = addr;
    step();
    dec_valid = 1'b0;
    model_decide(h, c, r, j, inc, addr);
    check_eq("dec_pc", pc, exp_pc);
    check_eq("dec_err", err, exp_err);
    check_eq("dec_halted", halted, exp_halted);
    check_eq("dec_mem_req", mem_req, !exp_halted);
    check_eq("dec_mem_addr", mem_addr, exp_pc);
    check_eq("dec_instr_valid", instr_valid, 1'b0);
  endtask

  task automatic instr(input int fd, input int dw, input logic h,
                       input logic c, input logic r, input logic j,
                       input logic inc, input logic [7:0] addr);
    do_fetch(fd, 8'($urandom));
    do_decide(dw, h, c, r, j, inc, addr);
  endtask

  initial begin
    logic [7:0] a;
    int         rv;
    rst = 1'b1; mem_ack = 1'b0; instr_in = '0; dec_valid = 1'b0;
    jmp = 1'b0; pc_inc = 1'b0; jmp_addr = '0; halt = 1'b0;
    call = 1'b0; ret = 1'b0;
    do_reset();

    // Sequential run 00..05, then a jump to 40 followed by an increment.
    for (int k = 0; k < 5; k++) instr(0, 0, 0, 0, 0, 0, 1, 8'h00);
    check_eq("seq_pc_05", pc, 8'h05);
    check_eq("seq_err", err, 1'b0);
    instr(0, 0, 0, 0, 0, 1, 0, 8'h40);
    instr(1, 1, 0, 0, 0, 0, 1, 8'h00);
    check_eq("jump_inc_pc", pc, 8'h41);
    // Wrap from FF to 00, then hold, which refetches 00.
    instr(0, 0, 0, 0, 0, 1, 0, 8'hFF);
    instr(0, 0, 0, 0, 0, 0, 1, 8'h00);
    check_eq("wrap_pc", pc, 8'h00);
    instr(0, 2, 0, 0, 0, 0, 0, 8'h00);
    // Three-cycle stall, then jmp and pc_inc together raise a sticky err.
    instr(3, 0, 0, 0, 0, 1, 1, 8'h77);
    check_eq("both_err", err, 1'b1);
    instr(0, 0, 0, 0, 0, 0, 1, 8'h00);
    check_eq("err_sticky", err, 1'b1);

`ifdef PC_CALL_STACK_EN
    do_reset();
    instr(0, 0, 0, 0, 0, 1, 0, 8'h10);
    instr(0, 0, 0, 1, 0, 0, 0, 8'h20);
    check_eq("call_pc", pc, 8'h20);
    instr(0, 0, 0, 0, 1, 0, 0, 8'h00);
    check_eq("ret_pc", pc, 8'h11);
    for (int k = 0; k < 5; k++) begin
      instr(0, 0, 0, 1, 0, 0, 0, 8'(8'h30 + k));
      check_eq("nest_err", err, k == 4);
    end
    for (int k = 0; k < 4; k++) instr(0, 0, 0, 0, 1, 0, 0, 8'h00);
    do_reset();
    instr(0, 0, 0, 0, 1, 0, 0, 8'h00);
    check_eq("ret_empty_pc", pc, 8'h01);
    check_eq("ret_empty_err", err, 1'b1);
`endif

    // Randomized instruction stream.
    do_reset();
    for (int k = 0; k < 60; k++) begin
      rv = $urandom_range(0, 9);
      instr($urandom_range(0, 3), $urandom_range(0, 2), 1'b0,
            STACK_EN && ($urandom_range(0, 5) == 0),
            STACK_EN && ($urandom_range(0, 5) == 0),
            rv < 3, rv >= 2, 8'($urandom));
    end

    // Halt: every input is ignored until reset.
    instr(0, 1, 1, 0, 0, 0, 1, 8'h00);
    for (int k = 0; k < 5; k++) begin
      dec_valid = 1'b1;
      mem_ack   = 1'b1;
      halt      = 1'($urandom_range(0, 1));
      jmp       = 1'($urandom_range(0, 1));
      pc_inc    = 1'b1;
      jmp_addr  = 8'($urandom);
      step();
      check_eq("halt_halted", halted, 1'b1);
      check_eq("halt_mem_req", mem_req, 1'b0);
      check_eq("halt_pc", pc, exp_pc);
      check_eq("halt_instr_valid", instr_valid, 1'b0);
    end
    dec_valid = 1'b0;
    mem_ack   = 1'b0;

    // Reset in the middle of a stalled fetch, with err set.
    do_reset();
    instr(0, 0, 0, 0, 0, 1, 1, 8'h33);
    check_eq("pre_rst_err", err, 1'b1);
    a = exp_q.pop_front();
    for (int k = 0; k < 2; k++) begin
      check_eq("midfetch_mem_req", mem_req, 1'b1);
      check_eq("midfetch_mem_addr", mem_addr, a);
      step();
    end
    do_reset();
    instr(0, 0, 0, 0, 0, 0, 1, 8'h00);
    check_eq("post_rst_pc", pc, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
